// File: rtl/mpc_div_div_36s_15s_21_seq.sv
// Sequential signed divider, 36s / 15s -> 21s quotient + 15s remainder.
// Restoring division on operand magnitudes, one bit per enabled clock, then sign fix-up and saturation.
module mpc_div_div_36s_15s_21_seq #(
    parameter logic [31:0] ID = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [35:0] din0,
    input  logic [14:0] din1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] quot,
    output logic [14:0] rem,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;

    localparam logic [20:0] QMAX = 21'h0FFFFF;
    localparam logic [20:0] QMIN = 21'h100000;

    state_t      state_q, state_d;
    logic [35:0] q_q;       // dividend bits shift out, quotient bits shift in
    logic [14:0] r_q;
    logic [14:0] d_q;
    logic        s0_q, s1_q, dzf_q;
    logic [5:0]  cnt_q;
    logic [20:0] quot_q;
    logic [14:0] rem_q;
    logic        ovf_q, dz_q;

    // Instance tag only.
    logic unused_id;
    assign unused_id = ^ID;

    logic [35:0] a_abs;
    logic [14:0] b_abs;
    assign a_abs = din0[35] ? 36'(-din0) : din0;
    assign b_abs = din1[14] ? 15'(-din1) : din1;

    // One restoring step.
    logic [15:0] r_sh, r_sub;
    logic        ge;
    logic [14:0] r_next;
    logic [35:0] q_next;
    always_comb begin
        r_sh   = {r_q, q_q[35]};
        r_sub  = r_sh - {1'b0, d_q};
        ge     = (r_sh >= {1'b0, d_q});
        r_next = ge ? r_sub[14:0] : r_sh[14:0];
        q_next = {q_q[34:0], ge};
    end

    // Sign fix-up and saturation of the final magnitudes.
    logic        neg;
    logic        ovf_c;
    logic [20:0] quot_c;
    logic [14:0] rem_c;
    always_comb begin
        neg    = s0_q ^ s1_q;
        ovf_c  = dzf_q | (neg ? (q_q > 36'd1048576) : (q_q > 36'd1048575));
        quot_c = neg ? 21'(-q_q[20:0]) : q_q[20:0];
        rem_c  = s0_q ? 15'(-r_q) : r_q;
        if (dzf_q) begin
            quot_c = s0_q ? QMIN : QMAX;
            rem_c  = '0;
        end else if (ovf_c) begin
            quot_c = neg ? QMIN : QMAX;
            rem_c  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else if (ce) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (cnt_q == 6'd35) state_d = FIX;
            FIX:  state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            dzf_q  <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    q_q   <= a_abs;
                    r_q   <= '0;
                    d_q   <= b_abs;
                    s0_q  <= din0[35];
                    s1_q  <= din1[14];
                    dzf_q <= (din1 == '0);
                    cnt_q <= '0;
                end
                CALC: begin
                    q_q <= q_next;
                    r_q <= r_next;
                    if (cnt_q != 6'd35) cnt_q <= cnt_q + 6'd1;
                end
                FIX: begin
                    quot_q <= quot_c;
                    rem_q  <= rem_c;
                    ovf_q  <= ovf_c;
                    dz_q   <= dzf_q;
                end
                default: ;
            endcase
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_mpc_div_div_36s_15s_21_seq.sv
// Randomized and directed checks of the sequential divider against a plain-arithmetic model.
module tb_mpc_div_div_36s_15s_21_seq;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_ready, out_valid, out_ready, ovf, dz;
    logic [35:0] din0;
    logic [14:0] din1;
    logic [20:0] quot;
    logic [14:0] rem;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mpc_div_div_36s_15s_21_seq #(.ID(32'd1)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .ovf(ovf), .dz(dz)
    );

    function automatic void model(input longint a, input longint b, output logic [20:0] eq,
                                  output logic [14:0] er, output logic eo, output logic ez);
        longint q, r;
        ez = (b == 0);
        eo = 1'b0;
        if (b == 0) begin
            eo = 1'b1;
            er = '0;
            eq = (a >= 0) ? 21'h0FFFFF : 21'h100000;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 1048575) begin
                eo = 1'b1; eq = 21'h0FFFFF; er = '0;
            end else if (q < -1048576) begin
                eo = 1'b1; eq = 21'h100000; er = '0;
            end else begin
                eq = q[20:0];
                er = r[14:0];
            end
        end
    endfunction

    task automatic do_op(input longint a, input longint b, input bit ce_rand, input int hold,
                         input bit busy_valid);
        logic [20:0] eq;
        logic [14:0] er;
        logic        eo, ez;
        int          n;
        bit          busy_ok, stable_ok;
        model(a, b, eq, er, eo, ez);
        @(negedge clk);
        ce = 1'b1; din0 = a[35:0]; din1 = b[14:0]; in_valid = 1'b1; out_ready = (hold == 0);
        total++;
        if (in_ready !== 1'b1) $display("FAIL idle_ready a=%0d b=%0d got %b want 1", a, b, in_ready);
        else passed++;
        @(posedge clk);
        n = 1;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 || n > 300) break;
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            in_valid = busy_valid;
            if (busy_valid) begin
                din0 = {4'($urandom), $urandom};
                din1 = 15'($urandom);
            end
            ce = ce_rand ? 1'($urandom % 2) : 1'b1;
            @(posedge clk);
            if (ce) n++;
        end
        in_valid = 1'b0;
        total++;
        if (!busy_ok) $display("FAIL busy_ready a=%0d b=%0d in_ready high while busy, want 0", a, b);
        else passed++;
        total++;
        if (n != 38 || out_valid !== 1'b1)
            $display("FAIL latency a=%0d b=%0d got %0d edges valid=%b want 38", a, b, n, out_valid);
        else passed++;
        total++;
        if (quot !== eq || rem !== er || ovf !== eo || dz !== ez)
            $display("FAIL result a=%0d b=%0d got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                     a, b, quot, rem, ovf, dz, eq, er, eo, ez);
        else passed++;
        if (hold > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                ce = 1'($urandom % 2);
                @(posedge clk);
                @(negedge clk);
                if (out_valid !== 1'b1 || quot !== eq || rem !== er || ovf !== eo || dz !== ez)
                    stable_ok = 1'b0;
            end
            total++;
            if (!stable_ok) $display("FAIL hold_stable a=%0d b=%0d outputs moved in HOLD, want q=%h r=%h", a, b, eq, er);
            else passed++;
            out_ready = 1'b1;
        end
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL pop a=%0d b=%0d got valid=%b ready=%b want 0/1", a, b, out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 || rem !== '0 || ovf !== 1'b0 || dz !== 1'b0)
            $display("FAIL reset_state got rdy=%b v=%b q=%h r=%h o=%b z=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quot, rem, ovf, dz);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        do_op(100, 7, 1'b0, 0, 1'b0);
        do_op(-100, 7, 1'b0, 0, 1'b0);
        do_op(100, -7, 1'b0, 0, 1'b0);
        do_op(64'sd1 <<< 30, 1, 1'b0, 0, 1'b0);
        do_op(-(64'sd1 <<< 35), 1, 1'b0, 0, 1'b0);
        do_op(-5, 0, 1'b0, 0, 1'b0);
        do_op(7, 0, 1'b0, 0, 1'b0);
        do_op(-(64'sd1 <<< 35), -16384, 1'b0, 0, 1'b0);
        do_op(-(64'sd1 <<< 35), 16384 * 2 - 32768 - 16384, 1'b0, 0, 1'b0);
        do_op(-3145728, 3, 1'b0, 0, 1'b0);
        do_op(1048575 * 16383 + 16382, 16383, 1'b0, 0, 1'b0);
        do_op(-1048577, 1, 1'b0, 0, 1'b0);
        do_op(0, 5, 1'b0, 0, 1'b0);
        do_op(-7, 7, 1'b0, 0, 1'b0);
        do_op(-3, 7, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        longint a, b;
        for (int i = 0; i < 40; i++) begin
            a = (longint'({$urandom, $urandom}) <<< 28) >>> 28;
            a = a >>> $urandom_range(0, 34);
            b = (longint'($urandom) <<< 49) >>> 49;
            b = b >>> $urandom_range(0, 14);
            do_op(a, b, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        do_op(100, 7, 1'b1, 10, 1'b1);
        do_op(-123456789, -321, 1'b1, 10, 1'b1);
        do_op(-5, 0, 1'b1, 4, 1'b1);
    endtask

    task automatic test_reset_mid_calc();
        bit quiet;
        @(negedge clk);
        ce = 1'b1; din0 = 36'd1000; din1 = 15'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 || rem !== '0 || ovf !== 1'b0 || dz !== 1'b0)
            $display("FAIL reset_calc got rdy=%b v=%b q=%h r=%h o=%b z=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quot, rem, ovf, dz);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) $display("FAIL reset_abandon got out_valid=1 after reset want 0");
        else passed++;
        do_op(100, 7, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        int n;
        @(negedge clk);
        ce = 1'b1; din0 = 36'd1000; din1 = 15'h7FFD; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1 || quot !== 21'h1FFEB3 || rem !== 15'd1)
            $display("FAIL hold_result got v=%b q=%h r=%h want 1 1ffeb3 0001", out_valid, quot, rem);
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== '0 || rem !== '0)
            $display("FAIL reset_hold got v=%b rdy=%b q=%h r=%h want 0 1 0 0", out_valid, in_ready, quot, rem);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        do_op(-100, 7, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
